// File: rtl/count_sequencer.sv
// Sequences a downstream up/down counter from start to end, one step per presc+1 cycles; done 3 cycles after the last step window.
// Accepts a command only in IDLE (cmd_ready); abort or rst cancels a run, wrap-around does not end it.
module count_sequencer #(
    parameter int WIDTH       = 8,
    parameter int PRESC_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [WIDTH-1:0]       cmd_start,
    input  logic [WIDTH-1:0]       cmd_end,
    input  logic                   cmd_dir,
    input  logic [PRESC_WIDTH-1:0] cmd_presc,
    input  logic                   abort,
    output logic                   cnt_load,
    output logic [WIDTH-1:0]       cnt_in,
    output logic                   cnt_up_down,
    output logic                   cnt_count_en,
    input  logic [WIDTH-1:0]       cnt_value,
    input  logic                   cnt_co,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted,
    output logic                   wrapped
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [WIDTH-1:0]       start_reg;
    logic [WIDTH-1:0]       end_reg;
    logic                   dir_reg;
    logic [PRESC_WIDTH-1:0] presc_reg;
    logic [PRESC_WIDTH-1:0] presc_cnt;
    logic [PRESC_WIDTH-1:0] presc_next;
    logic                   accept;
    logic                   step;

    always_comb begin
        state_next = state;
        presc_next = presc_cnt;
        accept     = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    accept     = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                presc_next = '0;
                state_next = abort ? IDLE : RUN;
            end
            RUN: begin
                // Reaching the terminal value wins over a pending step.
                if (cnt_value == end_reg) begin
                    state_next = DONE;
                end else if (presc_cnt == presc_reg) begin
                    step       = 1'b1;
                    presc_next = '0;
                end else begin
                    presc_next = presc_cnt + 1'b1;
                end
                if (abort) begin
                    state_next = IDLE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            presc_cnt <= '0;
            start_reg <= '0;
            end_reg   <= '0;
            dir_reg   <= 1'b0;
            presc_reg <= '0;
            wrapped   <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            state     <= state_next;
            presc_cnt <= presc_next;
            if (accept) begin
                start_reg <= cmd_start;
                end_reg   <= cmd_end;
                dir_reg   <= cmd_dir;
                presc_reg <= cmd_presc;
            end
            if (state == LOAD) begin
                wrapped <= 1'b0;
            end else if (state == RUN && cnt_co) begin
                wrapped <= 1'b1;
            end
            aborted <= abort && (state == LOAD || state == RUN);
        end
    end

    assign cmd_ready    = (state == IDLE) && !rst;
    assign cnt_load     = (state == LOAD) && !rst;
    assign cnt_count_en = step && !rst;
    assign cnt_in       = start_reg;
    assign cnt_up_down  = dir_reg;
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);

endmodule

// File: tb/tb_count_sequencer.sv
// Drives count_sequencer against a behavioural counter and a cycle-schedule model of each run.
module tb_count_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_start;
    logic [7:0] cmd_end;
    logic       cmd_dir;
    logic [7:0] cmd_presc;
    logic       abort;
    logic       cnt_load;
    logic [7:0] cnt_in;
    logic       cnt_up_down;
    logic       cnt_count_en;
    logic [7:0] cnt_value = 8'd0;
    logic       cnt_co = 1'b0;
    logic       busy;
    logic       done;
    logic       aborted;
    logic       wrapped;

    int total = 0;
    int bad   = 0;

    count_sequencer #(.WIDTH(8), .PRESC_WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_start    (cmd_start),
        .cmd_end      (cmd_end),
        .cmd_dir      (cmd_dir),
        .cmd_presc    (cmd_presc),
        .abort        (abort),
        .cnt_load     (cnt_load),
        .cnt_in       (cnt_in),
        .cnt_up_down  (cnt_up_down),
        .cnt_count_en (cnt_count_en),
        .cnt_value    (cnt_value),
        .cnt_co       (cnt_co),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted),
        .wrapped      (wrapped)
    );

    always #5 clk = ~clk;

    // Downstream counter: co pulses for one cycle after a step that wraps.
    always @(posedge clk) begin
        if (cnt_load) begin
            cnt_value <= cnt_in;
            cnt_co    <= 1'b0;
        end else if (cnt_count_en) begin
            if (cnt_up_down) begin
                cnt_co    <= (cnt_value == 8'hFF);
                cnt_value <= cnt_value + 8'd1;
            end else begin
                cnt_co    <= (cnt_value == 8'h00);
                cnt_value <= cnt_value - 8'd1;
            end
        end else begin
            cnt_co <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_junk();
        cmd_valid = 1'b1;
        cmd_start = 8'($urandom);
        cmd_end   = 8'($urandom);
        cmd_dir   = 1'($urandom);
        cmd_presc = 8'($urandom);
    endtask

    task automatic idle(input int k);
        cmd_valid = 1'b0;
        for (int i = 0; i < k; i++) begin
            abort = 1'($urandom);
            @(negedge clk);
            check("idle_ready", cmd_ready, 1);
            check("idle_busy", busy, 0);
            check("idle_load", cnt_load, 0);
            check("idle_en", cnt_count_en, 0);
            check("idle_done", done, 0);
        end
        abort = 1'b0;
    endtask

    // Entered at a negedge with the DUT in IDLE; leaves at a negedge with the DUT in IDLE.
    // ab_at: 0 none, >0 abort in that cycle, <0 abort in a random LOAD/RUN cycle.
    task automatic run_cmd(input logic [7:0] s, input logic [7:0] e, input logic d,
                           input logic [7:0] p, input int ab_at_in, input int rs_at);
        logic [7:0] diff;
        int n, p1, done_c, r, ab_at;
        bit exp_wrap, en_exp;
        diff     = d ? (e - s) : (s - e);
        n        = int'(diff);
        p1       = int'(p) + 1;
        done_c   = n * p1 + 3;
        exp_wrap = d ? (int'(s) + n > 255) : (int'(s) - n < 0);
        ab_at    = (ab_at_in < 0) ? int'($urandom_range(1, done_c - 1)) : ab_at_in;

        cmd_valid = 1'b1;
        cmd_start = s;
        cmd_end   = e;
        cmd_dir   = d;
        cmd_presc = p;
        abort     = 1'($urandom);
        rst       = 1'b0;
        #1;
        check("c0_ready", cmd_ready, 1);
        check("c0_busy", busy, 0);

        for (int c = 1; c <= done_c + 1; c++) begin
            @(negedge clk);
            if (c == done_c + 1) begin
                check("post_busy", busy, 0);
                check("post_done", done, 0);
                check("post_ready", cmd_ready, 1);
                check("post_wrapped", wrapped, 32'(exp_wrap));
                check("post_aborted", aborted, 0);
                return;
            end
            check("cnt_in", cnt_in, 32'(s));
            check("up_down", cnt_up_down, 32'(d));
            check("busy", busy, 1);
            check("ready_busy", cmd_ready, 0);
            check("aborted_run", aborted, 0);
            if (c == 1) begin
                check("load", cnt_load, 1);
                check("load_en", cnt_count_en, 0);
                check("load_done", done, 0);
            end else if (c < done_c) begin
                r      = c - 2;
                en_exp = ((r % p1) == p1 - 1) && (r / p1 < n);
                check("run_load", cnt_load, 0);
                check("run_en", cnt_count_en, 32'(en_exp));
                check("run_done", done, 0);
                if (c == 2) check("run_wrap_clr", wrapped, 0);
            end else begin
                check("done", done, 1);
                check("done_en", cnt_count_en, 0);
                check("done_wrapped", wrapped, 32'(exp_wrap));
            end

            drive_junk();
            abort = (c == done_c) ? 1'($urandom) : (c == ab_at);
            if (c == rs_at) begin
                rst = 1'b1;
                #1;
                check("rst_ready", cmd_ready, 0);
                check("rst_load", cnt_load, 0);
                check("rst_en", cnt_count_en, 0);
                @(negedge clk);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_aborted", aborted, 0);
                check("rst_wrapped", wrapped, 0);
                check("rst_cnt_in", cnt_in, 0);
                check("rst_ready_hold", cmd_ready, 0);
                rst       = 1'b0;
                cmd_valid = 1'b0;
                #1;
                check("rst_ready_rel", cmd_ready, 1);
                return;
            end
            if (c == ab_at) begin
                @(negedge clk);
                check("abort_aborted", aborted, 1);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                check("abort_ready", cmd_ready, 1);
                abort = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b1;
        cmd_start = 8'd9;
        cmd_end   = 8'd4;
        cmd_dir   = 1'b1;
        cmd_presc = 8'd2;
        abort     = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ready", cmd_ready, 0);
        check("reset_load", cnt_load, 0);
        check("reset_en", cnt_count_en, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_aborted", aborted, 0);
        check("reset_wrapped", wrapped, 0);
        check("reset_cnt_in", cnt_in, 0);
        check("reset_dir", cnt_up_down, 0);
        rst       = 1'b0;
        cmd_valid = 1'b0;
        idle(2);

        run_cmd(8'd3, 8'd5, 1'b1, 8'd1, 0, 0);
        idle(1);
        run_cmd(8'd7, 8'd7, 1'b0, 8'd9, 0, 0);
        idle(1);
        run_cmd(8'd254, 8'd1, 1'b1, 8'd0, 0, 0);
        run_cmd(8'd10, 8'd0, 1'b0, 8'd0, 4, 0);
        run_cmd(8'd2, 8'd250, 1'b0, 8'd1, 0, 0);
        run_cmd(8'd20, 8'd40, 1'b1, 8'd2, 0, 6);
        run_cmd(8'd5, 8'd2, 1'b0, 8'd1, 0, 0);
        run_cmd(8'd100, 8'd140, 1'b1, 8'd0, 1, 0);
        run_cmd(8'd0, 8'd255, 1'b0, 8'd0, 0, 0);

        for (int i = 0; i < 24; i++) begin
            run_cmd(8'($urandom), 8'($urandom), 1'($urandom), 8'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) == 0) ? -1 : 0, 0);
            idle(int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 Parameter WIDTH, default 8: width of the counter value, the start/end values and cnt_in.
REQ-002 Parameter PRESC_WIDTH, default 8: width of the prescaler setting.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port cmd_valid, input, 1: command offered.
REQ-006 Port cmd_ready, output, 1: command can be accepted.
REQ-007 Port cmd_start, input, WIDTH: value loaded into the counter.
REQ-008 Port cmd_end, input, WIDTH: terminal value.
REQ-009 Port cmd_dir, input, 1: 1 = count up, 0 = count down.
REQ-010 Port cmd_presc, input, PRESC_WIDTH: one count step every cmd_presc+1 cycles.
REQ-011 Port abort, input, 1: cancels the active run.
REQ-012 Port cnt_load, output, 1: load strobe to the downstream counter.
REQ-013 Port cnt_in, output, WIDTH: load value to the counter.
REQ-014 Port cnt_up_down, output, 1: direction to the counter.
REQ-015 Port cnt_count_en, output, 1: step enable to the counter.
REQ-016 Port cnt_value, input, WIDTH: current counter output.
REQ-017 Port cnt_co, input, 1: counter carry/borrow flag.
REQ-018 Port busy, output, 1: high when state is not IDLE.
REQ-019 Port done, output, 1: one-cycle pulse when the run completes.
REQ-020 Port aborted, output, 1: one-cycle pulse when a run is cancelled.
REQ-021 Port wrapped, output, 1: sticky flag, high once cnt_co has been seen during the current or last run.

Function
REQ-022 The block SHALL implement the states IDLE, LOAD, RUN and DONE.
REQ-023 In IDLE, cmd_ready SHALL be 1. On cmd_valid&cmd_ready, the block SHALL capture start, end, dir and presc into registers and go to LOAD.
REQ-024 In LOAD, the block SHALL drive cnt_load=1 and cnt_in=start_reg for exactly one cycle, clear wrapped and the prescaler counter, then go to RUN.
REQ-025 cnt_up_down SHALL equal dir_reg at all times. cnt_in SHALL equal start_reg at all times.
REQ-026 In RUN, if cnt_value==end_reg, the block SHALL go to DONE with cnt_count_en=0. This compare has priority over counting.
REQ-027 Otherwise in RUN, when presc_cnt==presc_reg, the block SHALL drive cnt_count_en=1 for that cycle and reset presc_cnt to 0. In all other RUN cycles, presc_cnt SHALL increment.
REQ-028 cnt_count_en SHALL be 0 outside RUN. cnt_load SHALL be 0 outside LOAD.
REQ-029 Counting SHALL be modulo 2^WIDTH. Step count N = (end-start) mod 2^WIDTH when counting up, and (start-end) mod 2^WIDTH when counting down. Wrap-around SHALL NOT terminate a run.
REQ-030 In RUN, cnt_co==1 SHALL set wrapped. wrapped SHALL hold until the next LOAD.
REQ-031 Latency: with the command accepted at edge 0, LOAD SHALL occupy cycle 1, RUN SHALL occupy cycles 2 .. N*(presc+1)+2, and done SHALL be high in cycle N*(presc+1)+3 (the DONE state). After that cycle the state SHALL return to IDLE.
REQ-032 start==end SHALL give N=0: no count_en pulse, and done in cycle 3.
REQ-033 abort sampled high in LOAD or RUN SHALL move the state to IDLE at the next edge. aborted SHALL be 1 for that following cycle, and done SHALL NOT assert.
REQ-034 abort SHALL be ignored in IDLE and DONE. If cmd_valid and abort are both high in IDLE, the command SHALL be accepted.
REQ-035 cmd_valid SHALL be ignored outside IDLE, and captured registers SHALL NOT change during a run.
REQ-036 All outputs except cnt_count_en SHALL be decoded from registered state only. cnt_count_en MAY depend combinationally on cnt_value.

Reset
REQ-037 rst high at a rising edge SHALL force state IDLE, presc_cnt=0, all captured registers=0, and wrapped=0, done=0, aborted=0.
REQ-038 While rst is high, cmd_ready, cnt_load and cnt_count_en SHALL be 0.
REQ-039 rst asserted mid-run SHALL abandon the run without a done or aborted pulse.

Verification
REQ-040 start=3, end=5, dir=1, presc=1, accepted at edge 0 -> cnt_load in cycle 1; count_en in cycles 3 and 5; done in cycle 7; wrapped=0.
REQ-041 start=7, end=7, presc=9 -> no count_en; done in cycle 3.
REQ-042 WIDTH=8, start=254, end=1, dir=1, presc=0 -> 3 count_en pulses; wrapped=1 after cnt_co; done in cycle 6.
REQ-043 start=10, end=0, dir=0, presc=0, abort in cycle 4 -> IDLE in cycle 5, aborted=1 in cycle 5, no done, cmd_ready=1 in cycle 5.
REQ-044 rst pulsed during RUN -> next cycle state IDLE, busy=0, no done or aborted; a new command is accepted normally.
REQ-045 Back-to-back: cmd_valid held high with a second command -> second command accepted in the cycle after done, never during busy.
